// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage unit with a 1-cycle integer ALU and iterative RV32M/RV64M multiply/divide.
// Build option ALU_MDU_FAST_MUL_EN: multiplies use a single-cycle 2*XLEN multiplier; divides stay iterative.
module alu_mdu #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2:0]          mop_q, mop_d;    // op[2:0] of the running mul/div
  logic [XLEN-1:0]     opb_q, opb_d;    // multiplicand or divisor
  logic [2*XLEN-1:0]   acc_q, acc_d;    // {hi, lo}: product, or {remainder, quotient}
  logic                neg_q, neg_d;
  logic                div0_q, div0_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Handshake: an op is taken on a rising edge where in_valid && in_ready && !flush;
  // a result is consumed on a rising edge where out_valid && out_ready.
  logic accept, is_iter;
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign result    = result_q;
  assign zero      = (result_q == '0);

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a    = (op == OP_MULHU) ? {{XLEN{1'b0}}, a} : {{XLEN{a[XLEN-1]}}, a};
    fast_b    = (op == OP_MULH)  ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    fast_prod = fast_a * fast_b;
  end
  assign is_iter = (op[4:2] == 3'b101);
`else
  assign is_iter = (op[4:3] == 2'b10);
`endif

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
`ifdef ALU_MDU_FAST_MUL_EN
      OP_MUL:    alu_res = fast_prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_res = fast_prod[2*XLEN-1:XLEN];
`endif
      default: alu_res = '0;
    endcase
  end

  // Operands are reduced to magnitudes; the sign is restored once at the end.
  logic            sa, sb, setup_neg;
  logic [XLEN-1:0] abs_a, abs_b, setup_opb, setup_lo;
  assign sa    = a[XLEN-1];
  assign sb    = b[XLEN-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  always_comb begin
    setup_opb = b;
    setup_lo  = a;
    setup_neg = 1'b0;
    case (op)
      OP_MULH:   begin setup_opb = abs_a; setup_lo = abs_b; setup_neg = sa ^ sb; end
      OP_MULHSU: begin setup_opb = abs_a; setup_lo = b;     setup_neg = sa;      end
      OP_DIV:    begin setup_opb = abs_b; setup_lo = abs_a; setup_neg = sa ^ sb; end
      OP_REM:    begin setup_opb = abs_b; setup_lo = abs_a; setup_neg = sa;      end
      default:   ;
    endcase
  end

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] nxt_acc, mul_full;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (!mop_q[2])
      nxt_acc = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_diff[XLEN])
      nxt_acc = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      nxt_acc = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    mul_full = neg_q ? -nxt_acc : nxt_acc;
    quo      = nxt_acc[XLEN-1:0];
    rem      = nxt_acc[2*XLEN-1:XLEN];
    if (!mop_q[2])
      fix_res = (mop_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    else if (!mop_q[1])
      fix_res = div0_q ? '1 : (neg_q ? -quo : quo);
    else
      fix_res = neg_q ? -rem : rem;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    mop_d    = mop_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    cnt_d    = cnt_q;
    case (state_q)
      CALC: begin
        acc_d = nxt_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          result_d = fix_res;
          state_d  = DONE;
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      mop_d = op[2:0];
      if (is_iter) begin
        opb_d   = setup_opb;
        acc_d   = {{XLEN{1'b0}}, setup_lo};
        neg_d   = setup_neg;
        div0_d  = (b == '0);
        cnt_d   = '0;
        state_d = CALC;
      end else begin
        result_d = alu_res;
        state_d  = DONE;
      end
    end
    // Abort drops any in-flight or pending result; the last registered value stays visible.
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      mop_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      mop_q    <= mop_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
